// File: rtl/fetch2_pkg.sv
// Shared types and constants for the fetch stage.
package fetch2_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD
    } fetch_state_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {instr, pc} buffer catching a response that arrives while decode is stalled.
module fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        rd,
    input  logic        clr,
    input  logic [31:0] wr_instr,
    input  logic [31:0] wr_pc,
    output logic        full,
    output logic [31:0] rd_instr,
    output logic [31:0] rd_pc
);

    logic        full_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    // A write in the same cycle as a read refills the entry, so write wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clr) begin
            full_q <= 1'b0;
        end else if (wr) begin
            full_q  <= 1'b1;
            instr_q <= wr_instr;
            pc_q    <= wr_pc;
        end else if (rd) begin
            full_q <= 1'b0;
        end
    end

    assign full     = full_q;
    assign rd_instr = instr_q;
    assign rd_pc    = pc_q;

endmodule

// File: rtl/fetch2.sv
// Instruction fetch stage: single-outstanding imem fetch, registered decode interface,
// stall skid buffer and redirect flush with late-response dropping.
module fetch2
    import fetch2_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = RV_NOP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        dec_stall,
    input  logic        exec_redirect,
    input  logic [31:0] exec_redirect_pc,
    output logic [31:0] ftch_dec_instr,
    output logic [31:0] ftch_dec_pc,
    output logic        ftch_dec_valid
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  faddr_q;
    logic         drop_q;

    logic         out_free;
    logic         resp_take;
    logic         skid_wr;
    logic         skid_rd;
    logic         skid_clr;
    logic         skid_full;
    logic         skid_full_next;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;

    assign imem_req  = (state_q == FS_REQ);
    assign imem_addr = pc_q;

    assign out_free  = !ftch_dec_valid || !dec_stall;
    assign resp_take = (state_q == FS_WAIT) && imem_rvalid && !drop_q && !exec_redirect;

    assign skid_clr       = exec_redirect;
    assign skid_rd        = !exec_redirect && out_free && skid_full;
    assign skid_wr        = resp_take && (!out_free || skid_full);
    assign skid_full_next = !exec_redirect && (skid_wr || (skid_full && !skid_rd));

    fetch_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .wr       (skid_wr),
        .rd       (skid_rd),
        .clr      (skid_clr),
        .wr_instr (imem_rdata),
        .wr_pc    (faddr_q),
        .full     (skid_full),
        .rd_instr (skid_instr),
        .rd_pc    (skid_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FS_IDLE;
            pc_q           <= RESET_PC;
            faddr_q        <= '0;
            drop_q         <= 1'b0;
            ftch_dec_valid <= 1'b0;
            ftch_dec_instr <= NOP_INSTR;
            ftch_dec_pc    <= '0;
        end else begin
            // The skid always holds older work than a fresh response.
            if (exec_redirect) begin
                ftch_dec_valid <= 1'b0;
                ftch_dec_instr <= NOP_INSTR;
            end else if (out_free) begin
                if (skid_full) begin
                    ftch_dec_valid <= 1'b1;
                    ftch_dec_instr <= skid_instr;
                    ftch_dec_pc    <= skid_pc;
                end else if (resp_take) begin
                    ftch_dec_valid <= 1'b1;
                    ftch_dec_instr <= imem_rdata;
                    ftch_dec_pc    <= faddr_q;
                end else begin
                    ftch_dec_valid <= 1'b0;
                    ftch_dec_instr <= NOP_INSTR;
                end
            end

            case (state_q)
                FS_IDLE: state_q <= FS_REQ;
                FS_REQ: begin
                    if (imem_gnt) begin
                        state_q <= FS_WAIT;
                        faddr_q <= pc_q;
                        pc_q    <= pc_q + 32'd4;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= skid_full_next ? FS_HOLD : FS_REQ;
                        drop_q  <= 1'b0;
                    end
                end
                FS_HOLD: begin
                    if (!skid_full_next) state_q <= FS_REQ;
                end
                default: state_q <= FS_IDLE;
            endcase

            // A redirect while a request is in flight must swallow its response.
            if (exec_redirect) begin
                pc_q <= word_align(exec_redirect_pc);
                if ((state_q == FS_REQ && imem_gnt) || (state_q == FS_WAIT && !imem_rvalid)) begin
                    drop_q <= 1'b1;
                end
            end
        end
    end

endmodule
